// File: rtl/l2_cache_control_nway_if.sv
// Control interface of the N-way L2 cache controller.
// Groups the upstream handshake (mem_*), the physical memory handshake (pmem_*),
// the per-set array status inputs and the array/datapath control outputs.
// Modports: master = the controller, slave = the datapath/memory side.
interface l2_cache_control_nway_if #(
  parameter int unsigned WAYS = 4,
  parameter int unsigned WIDX = $clog2(WAYS)
);
  logic              mem_read;
  logic              mem_write;
  logic              mem_resp;
  logic              pmem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [WAYS-1:0]   way_hit;
  logic [WAYS-1:0]   valid;
  logic [WAYS-1:0]   dirty;
  logic [WAYS-2:0]   plru;
  logic [WAYS-1:0]   valid_load;
  logic [WAYS-1:0]   dirty_load;
  logic [WAYS-1:0]   tag_load;
  logic              valid_datain;
  logic              dirty_datain;
  logic              plru_load;
  logic [WAYS-2:0]   plru_datain;
  logic [WAYS-1:0]   data_write;
  logic              data_src;
  logic              mbr_load;
  logic [WIDX-1:0]   dataout_sel;
  logic              pmem_addr_sel;

  modport master (
    input  mem_read, mem_write, pmem_resp, way_hit, valid, dirty, plru,
    output mem_resp, pmem_read, pmem_write, valid_load, dirty_load, tag_load,
           valid_datain, dirty_datain, plru_load, plru_datain, data_write,
           data_src, mbr_load, dataout_sel, pmem_addr_sel
  );

  modport slave (
    output mem_read, mem_write, pmem_resp, way_hit, valid, dirty, plru,
    input  mem_resp, pmem_read, pmem_write, valid_load, dirty_load, tag_load,
           valid_datain, dirty_datain, plru_load, plru_datain, data_write,
           data_src, mbr_load, dataout_sel, pmem_addr_sel
  );
endinterface

// File: rtl/l2_cache_control_nway.sv
// Control FSM for an N-way set-associative, write-back, write-allocate L2 cache.
// Ports: clk, rst (async active-low), bus (l2_cache_control_nway_if.master)
// carrying the mem_*/pmem_* handshakes, per-set status inputs and array controls.
// Optional feature: define L2_PLRU_EN for tree pseudo-LRU replacement; without
// it, non-invalid victims come from a global round-robin counter.
// Outputs are combinational from state (and lookup inputs); victim is latched
// once per miss and held through WRITEBACK/FILL/INSTALL.
module l2_cache_control_nway #(
  parameter int unsigned WAYS = 4,
  parameter int unsigned WIDX = $clog2(WAYS)
) (
  input logic clk,
  input logic rst,
  l2_cache_control_nway_if.master bus
);

  localparam int unsigned NW = WIDX + 1;

  // Reject unsupported associativity at elaboration.
  if (WAYS < 2 || WAYS > 16 || (WAYS & (WAYS - 1)) != 0 || WIDX != $clog2(WAYS)) begin : g_bad_ways
    $error("l2_cache_control_nway: WAYS must be a power of two in 2..16");
  end

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOOKUP, ST_WRITEBACK, ST_FILL, ST_INSTALL
  } state_e;

  state_e          state_q, state_d;
  logic [WIDX-1:0] victim_q, victim_d;
  logic            rr_pick_q, rr_pick_d;
  logic            hit, wr_only, any_invalid;
  logic [WIDX-1:0] hit_way, inv_way, repl_way, pick_way;
  logic [WAYS-1:0] victim_oh, hit_oh;

  // Lowest set bit index of a WAYS-wide vector.
  function automatic logic [WIDX-1:0] low_index(input logic [WAYS-1:0] v);
    logic [WIDX-1:0] idx;
    idx = '0;
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (v[i]) idx = WIDX'(i);
    end
    return idx;
  endfunction

  // Walk the heap-ordered tree from the root; bit 0 means victim is on the left.
  function automatic logic [WIDX-1:0] plru_victim(input logic [WAYS-2:0] t);
    logic [WIDX-1:0] w;
    logic [WIDX:0]   n;
    logic            b;
    w = '0;
    n = '0;
    for (int unsigned l = 0; l < WIDX; l++) begin
      b = t[n[WIDX-1:0]];
      w = WIDX'({w, b});
      n = {n[WIDX-1:0], 1'b0} + NW'(1) + NW'(b);
    end
    return w;
  endfunction

  // Point every node on way w's path away from w.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] t,
                                                 input logic [WIDX-1:0] w);
    logic [WAYS-2:0] r;
    logic [WIDX:0]   n;
    logic [WIDX-1:0] p;
    logic            b;
    r = t;
    n = '0;
    p = w;
    for (int unsigned l = 0; l < WIDX; l++) begin
      b = p[WIDX-1];
      r[n[WIDX-1:0]] = ~b;
      n = {n[WIDX-1:0], 1'b0} + NW'(1) + NW'(b);
      p = p << 1;
    end
    return r;
  endfunction

`ifdef L2_PLRU_EN
  assign repl_way = plru_victim(bus.plru);
`else
  logic [WIDX-1:0] rr_q, rr_d;
  logic            unused_plru;
  assign unused_plru = ^bus.plru;
  assign repl_way    = rr_q;
`endif

  // Victim choice: lowest invalid way first, else the replacement policy.
  assign any_invalid = ~&bus.valid;
  assign inv_way     = low_index(~bus.valid);
  assign pick_way    = any_invalid ? inv_way : repl_way;
  assign hit         = |bus.way_hit;
  assign hit_way     = low_index(bus.way_hit);
  assign hit_oh      = WAYS'(1) << hit_way;
  assign victim_oh   = WAYS'(1) << victim_q;
  assign wr_only     = bus.mem_write & ~bus.mem_read;

  // State, victim and round-robin registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      victim_q  <= '0;
      rr_pick_q <= 1'b0;
`ifndef L2_PLRU_EN
      rr_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      victim_q  <= victim_d;
      rr_pick_q <= rr_pick_d;
`ifndef L2_PLRU_EN
      rr_q      <= rr_d;
`endif
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d           = state_q;
    victim_d          = victim_q;
    rr_pick_d         = rr_pick_q;
`ifndef L2_PLRU_EN
    rr_d              = rr_q;
`endif
    bus.mem_resp      = 1'b0;
    bus.pmem_read     = 1'b0;
    bus.pmem_write    = 1'b0;
    bus.valid_load    = '0;
    bus.dirty_load    = '0;
    bus.tag_load      = '0;
    bus.valid_datain  = 1'b0;
    bus.dirty_datain  = 1'b0;
    bus.plru_load     = 1'b0;
    bus.plru_datain   = '0;
    bus.data_write    = '0;
    bus.data_src      = 1'b0;
    bus.mbr_load      = 1'b0;
    bus.dataout_sel   = '0;
    bus.pmem_addr_sel = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.mem_read || bus.mem_write) state_d = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (!(bus.mem_read || bus.mem_write)) begin
          state_d = ST_IDLE;
        end else if (hit) begin
          bus.mem_resp    = 1'b1;
          bus.dataout_sel = hit_way;
`ifdef L2_PLRU_EN
          bus.plru_load   = 1'b1;
          bus.plru_datain = plru_touch(bus.plru, hit_way);
`endif
          if (wr_only) begin
            bus.data_write   = hit_oh;
            bus.dirty_load   = hit_oh;
            bus.dirty_datain = 1'b1;
          end
          state_d = ST_IDLE;
        end else begin
          victim_d  = pick_way;
          rr_pick_d = ~any_invalid;
          state_d   = (bus.valid[pick_way] && bus.dirty[pick_way]) ? ST_WRITEBACK : ST_FILL;
        end
      end
      ST_WRITEBACK: begin
        bus.pmem_write    = 1'b1;
        bus.pmem_addr_sel = 1'b1;
        bus.dataout_sel   = victim_q;
        if (bus.pmem_resp) begin
          bus.dirty_load = victim_oh;
          state_d        = ST_FILL;
        end
      end
      ST_FILL: begin
        bus.pmem_read = 1'b1;
        bus.mbr_load  = 1'b1;
        if (bus.pmem_resp) state_d = ST_INSTALL;
      end
      ST_INSTALL: begin
        bus.tag_load     = victim_oh;
        bus.valid_load   = victim_oh;
        bus.valid_datain = 1'b1;
        bus.dirty_load   = victim_oh;
        bus.data_write   = victim_oh;
        bus.data_src     = 1'b1;
`ifndef L2_PLRU_EN
        if (rr_pick_q) rr_d = rr_q + WIDX'(1);
`endif
        state_d = ST_LOOKUP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_l2_cache_control_nway.sv
// Self-checking bench for l2_cache_control_nway (WAYS=4). A transaction-level
// cache model predicts the per-cycle control outputs; a small array emulation
// reacts to the DUT's load enables to provide way_hit/valid/dirty/plru.
module tb_l2_cache_control_nway;
  localparam int W  = 4;
  localparam int PW = W - 1;

  typedef struct packed {
    logic         resp, pread, pwrite;
    logic [W-1:0] vload, dload, tload, dwrite;
    logic         vdin, ddin, pload;
    logic [W-2:0] pdin;
    logic         dsrc, mbr;
    logic [1:0]   dsel;
    logic         asel;
  } outv_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l2_cache_control_nway_if #(.WAYS(W)) bus ();
  l2_cache_control_nway #(.WAYS(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  // Array emulation driven by the DUT's write enables.
  logic [W-1:0] dp_valid, dp_dirty;
  logic [7:0]   dp_tag [W];
  logic [W-2:0] dp_plru;
  logic [7:0]   cur_tag;
  logic         dp_clr, plru_clr, perturb_en;

  always_ff @(posedge clk) begin
    if (dp_clr) begin
      dp_valid <= '0;
      dp_dirty <= '0;
      dp_plru  <= '0;
      for (int w = 0; w < W; w++) dp_tag[w] <= '0;
    end else begin
      for (int w = 0; w < W; w++) begin
        if (bus.tag_load[w])   dp_tag[w]   <= cur_tag;
        if (bus.valid_load[w]) dp_valid[w] <= bus.valid_datain;
        if (bus.dirty_load[w]) dp_dirty[w] <= bus.dirty_datain;
      end
      if (plru_clr) dp_plru <= '0;
      else if (bus.plru_load) dp_plru <= bus.plru_datain;
    end
  end

  always_comb begin
    bus.way_hit = '0;
    for (int w = 0; w < W; w++) bus.way_hit[w] = dp_valid[w] && (dp_tag[w] == cur_tag);
    bus.valid = dp_valid;
    bus.dirty = dp_dirty;
    bus.plru  = perturb_en ? ~dp_plru : dp_plru;
  end

  outv_t act;
  always_comb begin
    act        = '0;
    act.resp   = bus.mem_resp;
    act.pread  = bus.pmem_read;
    act.pwrite = bus.pmem_write;
    act.vload  = bus.valid_load;
    act.dload  = bus.dirty_load;
    act.tload  = bus.tag_load;
    act.dwrite = bus.data_write;
    act.vdin   = bus.valid_datain;
    act.ddin   = bus.dirty_datain;
    act.pload  = bus.plru_load;
    act.pdin   = bus.plru_datain;
    act.dsrc   = bus.data_src;
    act.mbr    = bus.mbr_load;
    act.dsel   = bus.dataout_sel;
    act.asel   = bus.pmem_addr_sel;
  end

  // Expected-output queue, consumed one entry per cycle.
  outv_t exp_q [$];
  string name_q [$];

  task automatic push(input outv_t e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin : cmp
    outv_t e;
    string nm;
    if (rst && exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_tests++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, e);
      end
    end
  end

  task automatic check_int(input string nm, input int got, input int expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, expv);
    end
  endtask

  // Cache model: one set, tags/valid/dirty per way plus replacement state.
  logic [W-1:0] m_valid, m_dirty;
  logic [7:0]   m_tag [W];
  logic [W-2:0] m_plru;
  int           m_rr;

  // Tree PLRU as interval bisection: bit 0 at a node sends the victim low.
  function automatic int m_pick(input logic [W-2:0] t);
    int lo, hi, mid, node;
    lo = 0; hi = W; node = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (((t >> node) & 1) == 0) begin hi = mid; node = 2 * node + 1; end
      else begin lo = mid; node = 2 * node + 2; end
    end
    return lo;
  endfunction

  function automatic logic [W-2:0] m_touch(input logic [W-2:0] t, input int w);
    int lo, hi, mid, node;
    lo = 0; hi = W; node = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (w < mid) begin t = t | (PW'(1) << node); hi = mid; node = 2 * node + 1; end
      else begin t = t & ~(PW'(1) << node); lo = mid; node = 2 * node + 2; end
    end
    return t;
  endfunction

  function automatic outv_t e_hit(input int w, input bit wr);
    outv_t e;
    e = '0;
    e.resp = 1'b1;
    e.dsel = 2'(w);
`ifdef L2_PLRU_EN
    e.pload = 1'b1;
    e.pdin  = m_touch(m_plru, w);
`endif
    if (wr) begin
      e.dwrite = W'(1) << w;
      e.dload  = W'(1) << w;
      e.ddin   = 1'b1;
    end
    return e;
  endfunction

  task automatic m_access(input int w, input bit wr);
    push(e_hit(w, wr), wr ? "write_hit" : "read_hit");
    m_plru = m_touch(m_plru, w);
    if (wr) m_dirty[w] = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    push('0, "idle");
    step();
  endtask

  // One upstream request from IDLE to completion (or reset abort in FILL).
  task automatic do_req(input bit rd, input bit wr, input logic [7:0] tag,
                        input int wb_n, input int fill_n, input bit perturb,
                        input bit abort, output int vict, output bit wb_done);
    outv_t e;
    int  hw, v;
    bit  by_rr, wrx;
    wrx = wr && !rd;
    vict = -1; wb_done = 0;
    cur_tag = tag; bus.mem_read = rd; bus.mem_write = wr;
    push('0, "idle_req");
    step();
    hw = -1;
    for (int w = 0; w < W; w++) if (hw < 0 && m_valid[w] && m_tag[w] == tag) hw = w;
    if (hw >= 0) begin
      m_access(hw, wrx);
      step();
      bus.mem_read = 0; bus.mem_write = 0;
      vict = hw;
      return;
    end
    v = -1; by_rr = 0;
    for (int w = 0; w < W; w++) if (v < 0 && !m_valid[w]) v = w;
    if (v < 0) begin
`ifdef L2_PLRU_EN
      v = m_pick(m_plru);
`else
      v = m_rr; by_rr = 1;
`endif
    end
    vict = v;
    push('0, "lookup_miss");
    step();
    if (m_valid[v] && m_dirty[v]) begin
      for (int i = 0; i < wb_n; i++) begin
        bus.pmem_resp = (i == wb_n - 1);
        e = '0; e.pwrite = 1; e.asel = 1; e.dsel = 2'(v);
        if (i == wb_n - 1) e.dload = W'(1) << v;
        push(e, "writeback");
        step();
      end
      bus.pmem_resp = 0;
      m_dirty[v] = 1'b0;
      wb_done = 1;
    end
    for (int i = 0; i < fill_n; i++) begin
      bus.pmem_resp = (i == fill_n - 1);
      perturb_en = perturb;
      if (abort) begin
        #1 check_int("fill_pmem_read_before_reset", int'(bus.pmem_read), 1);
        rst = 1'b0;
        #1;
        check_int("reset_kills_pmem_read", int'(bus.pmem_read), 0);
        check_int("reset_no_array_loads",
                  int'(|{bus.tag_load, bus.valid_load, bus.dirty_load, bus.data_write, bus.plru_load}), 0);
        check_int("reset_no_resp_or_write", int'(bus.mem_resp | bus.pmem_write | bus.mbr_load), 0);
        bus.pmem_resp = 0; perturb_en = 0; bus.mem_read = 0; bus.mem_write = 0;
        m_rr = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        return;
      end
      e = '0; e.pread = 1; e.mbr = 1;
      push(e, "fill");
      step();
    end
    bus.pmem_resp = 0; perturb_en = 0;
    e = '0;
    e.tload = W'(1) << v; e.vload = W'(1) << v; e.dload = W'(1) << v;
    e.dwrite = W'(1) << v; e.vdin = 1; e.dsrc = 1;
    push(e, "install");
    m_tag[v] = tag; m_valid[v] = 1'b1; m_dirty[v] = 1'b0;
    if (by_rr) m_rr = (m_rr + 1) % W;
    step();
    m_access(v, wrx);
    step();
    bus.mem_read = 0; bus.mem_write = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int  v;
    bit  wb;
    int  rr_seq [5];
    int  rr_exp [5];
    rr_exp = '{0, 1, 2, 3, 0};
    rst = 1'b0; dp_clr = 1'b1; plru_clr = 1'b0; perturb_en = 1'b0; cur_tag = '0;
    bus.mem_read = 0; bus.mem_write = 0; bus.pmem_resp = 0;
    m_valid = '0; m_dirty = '0; m_plru = '0; m_rr = 0;
    for (int w = 0; w < W; w++) m_tag[w] = '0;
    repeat (2) @(posedge clk);
    #1;
    check_int("reset_outputs_zero", int'(act != '0), 0);
    dp_clr = 1'b0;
    rst = 1'b1;
    step();
    idle_cycle();

    // Read miss on an empty set installs way 0.
    do_req(1, 0, 8'hA0, 0, 2, 0, 0, v, wb);
    check_int("first_victim_way0", v, 0);
    check_int("first_install_valid", int'(dp_valid), 1);
    check_int("first_install_clean", int'(dp_dirty), 0);
`ifdef L2_PLRU_EN
    check_int("plru_after_first_fill", int'(dp_plru), 3);
`else
    check_int("plru_untouched_rr", int'(dp_plru), 0);
`endif

    // Fill remaining ways via invalid-first.
    do_req(1, 0, 8'hB1, 0, 1, 0, 0, v, wb);
    check_int("second_victim_way1", v, 1);
    do_req(1, 0, 8'hC2, 0, 3, 0, 0, v, wb);
    do_req(1, 0, 8'hD3, 0, 1, 0, 0, v, wb);
    check_int("fourth_victim_way3", v, 3);

    // Write hit on way 2, then read+write together (read wins, no write).
    do_req(0, 1, 8'hC2, 0, 1, 0, 0, v, wb);
    check_int("write_hit_way2", v, 2);
    check_int("write_hit_sets_dirty", int'(dp_dirty), 4);
    do_req(1, 1, 8'hB1, 0, 1, 0, 0, v, wb);
    check_int("read_priority_no_dirty", int'(dp_dirty), 4);

    // Dirty way 0 with PLRU cleared: write-back then refill of way 0.
    do_req(0, 1, 8'hA0, 0, 1, 0, 0, v, wb);
    plru_clr = 1'b1; m_plru = '0;
    idle_cycle();
    plru_clr = 1'b0;
    do_req(1, 0, 8'hE4, 2, 2, 0, 0, v, wb);
    check_int("dirty_miss_victim_way0", v, 0);
    check_int("dirty_miss_wrote_back", int'(wb), 1);
    check_int("refilled_way0_tag", int'(dp_tag[0]), 8'hE4);

    // PLRU input flipped during FILL must not move the install target.
    do_req(1, 0, 8'hF5, 1, 3, 1, 0, v, wb);
`ifdef L2_PLRU_EN
    check_int("perturbed_fill_victim", v, 2);
`else
    check_int("perturbed_fill_victim", v, 1);
`endif
    check_int("perturbed_fill_tag", int'(dp_tag[v]), 8'hF5);

    // Reset in the middle of FILL.
    do_req(1, 0, 8'h66, 1, 2, 0, 1, v, wb);
    idle_cycle();

    // Five conflicting misses; last one is a write-allocate.
    for (int k = 0; k < 5; k++) begin
      do_req(1'(k != 4), 1'(k == 4), 8'(8'h70 + k), 1, 1, 0, 0, v, wb);
      rr_seq[k] = v;
    end
    check_int("write_alloc_dirty", int'(dp_dirty[rr_seq[4]]), 1);
`ifndef L2_PLRU_EN
    for (int k = 0; k < 5; k++) check_int($sformatf("rr_victim_%0d", k), rr_seq[k], rr_exp[k]);
    check_int("rr_plru_never_loaded", int'(dp_plru), 0);
`endif
    idle_cycle();
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/l2_cache_control_nway.md
# l2_cache_control_nway

Parametrised control FSM for an N-way set-associative, write-back, write-allocate L2 cache. It sits between the L1/arbiter side (`mem_*`) and physical memory (`pmem_*`) and drives a WAYS-wide datapath of tag, valid, dirty and data arrays. It generalises the 2-way controller in three ways:
- tree pseudo-LRU replacement for any power-of-two way count;
- a victim way latched once per miss;
- dirty-clear on write-back instead of invalidation.

## Interface
Parameters:
- WAYS, 4, associativity; power of two, 2..16; any other value is an elaboration error.
- WIDX, $clog2(WAYS), way-index width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- mem_read / mem_write  in  1  upstream request, held until mem_resp.
- mem_resp  out  1  one-cycle completion pulse.
- pmem_resp  in  1  physical memory burst done.
- pmem_read / pmem_write  out  1  physical memory request, held until pmem_resp.
- way_hit  in  WAYS  per-way tag-match-and-valid for the indexed set.
- valid / dirty  in  WAYS  per-way valid/dirty bits for the indexed set.
- plru  in  WAYS-1  PLRU tree bits for the indexed set.
- valid_load / dirty_load / tag_load  out  WAYS  per-way array write enables.
- valid_datain / dirty_datain  out  1  value written to the enabled valid/dirty bits.
- plru_load  out  1  PLRU write enable.
- plru_datain  out  WAYS-1  updated PLRU tree.
- data_write  out  WAYS  per-way data-array write enable.
- data_src  out  1  data source: 0 = CPU write data with byte enables, 1 = memory buffer register (whole line).
- mbr_load  out  1  capture the pmem line into the memory buffer register.
- dataout_sel  out  WIDX  way routed to upstream rdata and pmem wdata.
- pmem_addr_sel  out  1  0 = request tag/index, 1 = victim tag/index.

## Operation
States: IDLE, LOOKUP, WRITEBACK, FILL, INSTALL. Outputs are combinational from the state; every output defaults to 0.

IDLE
- Go to LOOKUP when mem_read or mem_write is asserted.

LOOKUP
- hit = |way_hit.
- Hit:
  - assert mem_resp;
  - dataout_sel = index of the hit way;
  - PLRU update on the hit way;
  - go to IDLE.
- Write hit:
  - data_write[hw]=1, data_src=0;
  - dirty_load[hw]=1, dirty_datain=1.
- Miss:
  - latch the victim into victim_q;
  - if valid[victim] && dirty[victim], go to WRITEBACK; otherwise go to FILL.
- Neither request asserted: go to IDLE with no side effects.
- Both asserted: read takes priority; no write.

Victim selection
- Lowest-index invalid way, if any.
- Otherwise the PLRU victim: heap-ordered tree, node 0 is the root, children of node i are 2i+1 and 2i+2. Bit 0 = victim in the left (lower) subtree. Walk from the root following the bits.

PLRU update on access to way w
- Every node on w's path is set to point away from w.
- All other bits pass through unchanged.

WRITEBACK
- pmem_write=1, pmem_addr_sel=1, dataout_sel=victim_q.
- On pmem_resp:
  - dirty_load[victim_q]=1, dirty_datain=0;
  - go to FILL.

FILL
- pmem_read=1, pmem_addr_sel=0, mbr_load=1.
- On pmem_resp, go to INSTALL.

INSTALL (victim_q)
- tag_load=1.
- valid_load=1, valid_datain=1.
- dirty_load=1, dirty_datain=0.
- data_write=1, data_src=1.
- Go to LOOKUP; the replay now hits. A write completes there and sets dirty.

victim_q is loaded only in a LOOKUP miss cycle. It holds across WRITEBACK, FILL and INSTALL even if the datapath's plru or valid inputs change.

## Timing
- Reset (rst low, asynchronous):
  - state=IDLE, victim_q=0, round-robin counter=0;
  - all outputs 0 immediately, including an in-flight pmem_read or pmem_write, which is abandoned.
- Hit latency: request seen in IDLE at cycle 0; mem_resp in cycle 1.
- Clean miss: LOOKUP(1) + FILL(≥1, until pmem_resp) + INSTALL(1) + LOOKUP(1, resp). Total 4 + pmem wait cycles.
- Dirty miss: adds WRITEBACK (≥1, until pmem_resp) ahead of FILL.
- pmem_resp is sampled only in WRITEBACK and FILL; it is ignored in other states.
- PLRU is written only in a LOOKUP hit cycle, never in INSTALL. The replay hit performs the fill's PLRU update.

## Configuration
- L2_PLRU_EN defined:
  - tree PLRU as described;
  - plru input used;
  - plru_load and plru_datain driven.
- Undefined:
  - plru_load is held at 0 and the plru input is ignored;
  - non-invalid victims come from a global WIDX-bit round-robin counter;
  - the counter increments (wrapping WAYS-1→0) in each INSTALL cycle whose victim was chosen by it;
  - invalid-first selection is still applied.

## Test plan
- WAYS=4, reset, then read miss on an empty set:
  - victim=0, FILL, INSTALL writes way 0 (valid=1, dirty=0);
  - replay hit, mem_resp;
  - plru_datain=3'b011 (node0→right, node1→way1).
- Write hit on way 2 with dirty=0:
  - data_write=4'b0100, data_src=0, dirty_load=4'b0100, dirty_datain=1;
  - mem_resp in cycle 1.
- Set full, plru=3'b000, dirty[0]=1, read miss:
  - WRITEBACK with dataout_sel=0, pmem_addr_sel=1;
  - on pmem_resp, dirty_load=4'b0001, dirty_datain=0;
  - then FILL and INSTALL into way 0.
- Miss with the plru input changed mid-FILL: INSTALL still targets the latched victim_q.
- rst low during FILL with pmem_read=1: pmem_read=0 within the same cycle, state=IDLE, no array loads.
- L2_PLRU_EN undefined, set full, 5 consecutive conflicting misses: victims 0,1,2,3,0; plru_load stays 0.
